// File: rtl/gmii_frame_gen_if.sv
// Request/status bundle and per-channel GMII outputs of gmii_frame_gen.
// master = frame requester, slave = generator.
interface gmii_frame_gen_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int PSW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic                  start_i;
  logic [PSW-1:0]        port_sel_i;
  logic [47:0]           dst_mac_i;
  logic [47:0]           src_mac_i;
  logic [15:0]           eth_type_i;
  logic [10:0]           payload_len_i;
  logic                  fcs_err_i;
  logic                  rx_er_i;
  logic                  ready_o;
  logic                  done_o;
  logic [15:0]           frame_cnt_o;
  logic [DATA_WIDTH-1:0] gmii_data_o [NUM_PORTS];
  logic [NUM_PORTS-1:0]  gmii_dv_o;
  logic [NUM_PORTS-1:0]  gmii_er_o;

  modport master (
    output start_i, port_sel_i, dst_mac_i, src_mac_i, eth_type_i,
           payload_len_i, fcs_err_i, rx_er_i,
    input  ready_o, done_o, frame_cnt_o, gmii_data_o, gmii_dv_o, gmii_er_o
  );

  modport slave (
    input  start_i, port_sel_i, dst_mac_i, src_mac_i, eth_type_i,
           payload_len_i, fcs_err_i, rx_er_i,
    output ready_o, done_o, frame_cnt_o, gmii_data_o, gmii_dv_o, gmii_er_o
  );
endinterface

// File: rtl/gmii_frame_gen.sv
// Ethernet frame generator driving one of NUM_PORTS GMII channels, one byte per cycle.
//   state    | meaning
//   IDLE     | ready_o high, waiting for start_i
//   PREAMBLE | 7 x 0x55
//   SFD      | 0xD5
//   DST/SRC  | 6-byte MAC addresses, MSB first
//   TYPE     | EtherType, MSB first
//   PAYLOAD  | byte i = i[7:0]
//   PAD      | zeros up to 46 data bytes
//   FCS      | CRC-32 complement, LSB first
//   IFG      | idle gap, dv low
module gmii_frame_gen #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_PAYLOAD = 1500,
  parameter int IFG_CYCLES  = 12
) (
  input logic             gmii_clk_i,
  input logic             gmii_rst_i,
  gmii_frame_gen_if.slave bus
);
  localparam int PSW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MIN_PAYLOAD = 46;
  localparam int CNT_MAX     = (MAX_PAYLOAD + MIN_PAYLOAD > IFG_CYCLES) ?
                               MAX_PAYLOAD + MIN_PAYLOAD : IFG_CYCLES;
  localparam int CW0         = $clog2(CNT_MAX + 1);
  localparam int CW          = (CW0 > 11) ? CW0 : 11;

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DST, S_SRC, S_TYPE, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t         state, nxt_state;
  logic [CW-1:0]  rem, nxt_rem;
  logic [CW-1:0]  len_q, pad_len;
  logic [PSW-1:0] port_q, nxt_port;
  logic [47:0]    dst_q, src_q;
  logic [15:0]    type_q;
  logic           fcs_err_q, rx_er_q;
  logic           accept, nxt_dv, nxt_er, crc_on;
  logic [7:0]     byte_q, nxt_byte;
  logic [31:0]    crc, crc_nxt, fcs;

  function automatic logic [31:0] crc32_byte(logic [31:0] c, logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign pad_len = (len_q < CW'(MIN_PAYLOAD)) ? CW'(MIN_PAYLOAD) - len_q : '0;
  assign crc_on  = state inside {S_DST, S_SRC, S_TYPE, S_PAYLOAD, S_PAD};
  assign crc_nxt = crc_on ? crc32_byte(crc, byte_q) : crc;
  assign fcs     = ~crc_nxt;

  // IFG holds IFG_CYCLES-1 cycles; the IDLE cycle with ready_o high is the last
  // idle cycle, so a back-to-back start gives exactly IFG_CYCLES dv-low cycles.
  always_comb begin
    nxt_state = state;
    nxt_rem   = rem - CW'(1);
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        nxt_rem = rem;
        if (bus.start_i) begin
          accept    = 1'b1;
          nxt_state = S_PREAMBLE;
          nxt_rem   = CW'(6);
        end
      end
      S_PREAMBLE: if (rem == '0) begin nxt_state = S_SFD; nxt_rem = '0; end
      S_SFD:      begin nxt_state = S_DST; nxt_rem = CW'(5); end
      S_DST:      if (rem == '0) begin nxt_state = S_SRC; nxt_rem = CW'(5); end
      S_SRC:      if (rem == '0) begin nxt_state = S_TYPE; nxt_rem = CW'(1); end
      S_TYPE: if (rem == '0) begin
        if (len_q != '0) begin nxt_state = S_PAYLOAD; nxt_rem = len_q - CW'(1); end
        else begin nxt_state = S_PAD; nxt_rem = CW'(MIN_PAYLOAD - 1); end
      end
      S_PAYLOAD: if (rem == '0) begin
        if (pad_len != '0) begin nxt_state = S_PAD; nxt_rem = pad_len - CW'(1); end
        else begin nxt_state = S_FCS; nxt_rem = CW'(3); end
      end
      S_PAD: if (rem == '0) begin nxt_state = S_FCS; nxt_rem = CW'(3); end
      S_FCS: if (rem == '0) begin nxt_state = S_IFG; nxt_rem = CW'(IFG_CYCLES - 2); end
      S_IFG: if (rem == '0) begin nxt_state = S_IDLE; nxt_rem = '0; end
      default: begin nxt_state = S_IDLE; nxt_rem = '0; end
    endcase
  end

  always_comb begin
    nxt_byte = 8'h00;
    case (nxt_state)
      S_PREAMBLE: nxt_byte = 8'h55;
      S_SFD:      nxt_byte = 8'hD5;
      S_DST:      nxt_byte = dst_q[{nxt_rem[2:0], 3'b000} +: 8];
      S_SRC:      nxt_byte = src_q[{nxt_rem[2:0], 3'b000} +: 8];
      S_TYPE:     nxt_byte = nxt_rem[0] ? type_q[15:8] : type_q[7:0];
      S_PAYLOAD:  nxt_byte = 8'(len_q - CW'(1) - nxt_rem);
      S_FCS: begin
        case (nxt_rem[1:0])
          2'd3:    nxt_byte = fcs[7:0] ^ {7'b0, fcs_err_q};
          2'd2:    nxt_byte = fcs[15:8];
          2'd1:    nxt_byte = fcs[23:16];
          default: nxt_byte = fcs[31:24];
        endcase
      end
      default:    nxt_byte = 8'h00;
    endcase
  end

  assign nxt_port = accept ? bus.port_sel_i : port_q;
  assign nxt_dv   = nxt_state inside {S_PREAMBLE, S_SFD, S_DST, S_SRC, S_TYPE,
                                      S_PAYLOAD, S_PAD, S_FCS};
  assign nxt_er   = rx_er_q && (nxt_state == S_PAYLOAD) && (state != S_PAYLOAD);

  always_ff @(posedge gmii_clk_i) begin
    if (gmii_rst_i) begin
      state           <= S_IDLE;
      rem             <= '0;
      crc             <= '1;
      byte_q          <= '0;
      port_q          <= '0;
      bus.ready_o     <= 1'b1;
      bus.done_o      <= 1'b0;
      bus.frame_cnt_o <= '0;
      bus.gmii_dv_o   <= '0;
      bus.gmii_er_o   <= '0;
      for (int p = 0; p < NUM_PORTS; p++) bus.gmii_data_o[p] <= '0;
    end else begin
      state  <= nxt_state;
      rem    <= nxt_rem;
      byte_q <= nxt_byte;
      port_q <= nxt_port;
      crc    <= accept ? '1 : crc_nxt;
      if (accept) begin
        dst_q     <= bus.dst_mac_i;
        src_q     <= bus.src_mac_i;
        type_q    <= bus.eth_type_i;
        fcs_err_q <= bus.fcs_err_i;
        rx_er_q   <= bus.rx_er_i;
        len_q     <= (CW'(bus.payload_len_i) > CW'(MAX_PAYLOAD)) ?
                     CW'(MAX_PAYLOAD) : CW'(bus.payload_len_i);
      end
      bus.ready_o <= (nxt_state == S_IDLE);
      bus.done_o  <= (state == S_FCS) && (nxt_state == S_IFG);
      if ((state == S_FCS) && (nxt_state == S_IFG))
        bus.frame_cnt_o <= bus.frame_cnt_o + 16'd1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        bus.gmii_data_o[p] <= (nxt_dv && PSW'(p) == nxt_port) ? DATA_WIDTH'(nxt_byte) : '0;
        bus.gmii_dv_o[p]   <= nxt_dv && (PSW'(p) == nxt_port);
        bus.gmii_er_o[p]   <= nxt_er && (PSW'(p) == nxt_port);
      end
    end
  end
endmodule

// File: tb/tb_gmii_frame_gen.sv
// Bench for gmii_frame_gen: each frame is rebuilt as a byte list from the
// Ethernet framing rules and compared with what the selected channel emits.
module tb_gmii_frame_gen;
  localparam int NP   = 4;
  localparam int IFG  = 12;
  localparam int MAXP = 1500;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gmii_frame_gen_if #(.NUM_PORTS(NP), .DATA_WIDTH(8)) bus ();

  gmii_frame_gen #(
    .NUM_PORTS(NP), .DATA_WIDTH(8), .MAX_PAYLOAD(MAXP), .IFG_CYCLES(IFG)
  ) dut (
    .gmii_clk_i(clk),
    .gmii_rst_i(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int model_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    total++;
    if (obs !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, req);
    end
  endtask

  // Bit-serial reflected CRC-32 over exp_q[first..end], complemented.
  function automatic logic [31:0] ref_crc(input int first);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    for (int i = first; i < exp_q.size(); i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ exp_q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    return ~c;
  endfunction

  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] typ, input int len, input bit fe);
    int l;
    logic [31:0] f;
    l = (len > MAXP) ? MAXP : len;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) exp_q.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(src[i*8 +: 8]);
    exp_q.push_back(typ[15:8]);
    exp_q.push_back(typ[7:0]);
    for (int i = 0; i < l; i++) exp_q.push_back(8'(i));
    for (int i = l; i < 46; i++) exp_q.push_back(8'h00);
    f = ref_crc(8);
    exp_q.push_back(f[7:0] ^ {7'b0, fe});
    exp_q.push_back(f[15:8]);
    exp_q.push_back(f[23:16]);
    exp_q.push_back(f[31:24]);
  endtask

  task automatic send(input int port, input logic [47:0] dst, input logic [47:0] src,
                      input logic [15:0] typ, input int len, input bit fe, input bit re,
                      input int rst_at);
    int n, er_n, er_at, other, l, nbad, sz;
    l = (len > MAXP) ? MAXP : len;
    build_frame(dst, src, typ, len, fe);
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("ready_before_start", bus.ready_o, 1);
    bus.port_sel_i    = 2'(port);
    bus.dst_mac_i     = dst;
    bus.src_mac_i     = src;
    bus.eth_type_i    = typ;
    bus.payload_len_i = 11'(len);
    bus.fcs_err_i     = fe;
    bus.rx_er_i       = re;
    bus.start_i       = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("busy_after_start", bus.ready_o, 0);
    got_q.delete();
    er_n = 0; er_at = -1; other = 0; n = 0;
    while (bus.gmii_dv_o[port] === 1'b1 && n < 4000) begin
      got_q.push_back(bus.gmii_data_o[port]);
      if (bus.gmii_er_o[port]) begin er_n++; if (er_at < 0) er_at = n; end
      for (int p = 0; p < NP; p++)
        if (p != port && (bus.gmii_dv_o[p] || bus.gmii_er_o[p] || bus.gmii_data_o[p] != 8'h00))
          other++;
      if (n == rst_at) break;
      if (n == 30) begin bus.start_i = 1'b1; bus.port_sel_i = 2'((port + 1) % NP); end
      else if (n == 31) begin bus.start_i = 1'b0; bus.port_sel_i = 2'(port); end
      @(negedge clk);
      n++;
    end
    if (rst_at >= 0) begin
      check("rst_reached_byte", n, rst_at);
      check("rst_payload_byte20", got_q[got_q.size()-1], 8'd20);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_dv", bus.gmii_dv_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_ready", bus.ready_o, 1);
      check("rst_frame_cnt", bus.frame_cnt_o, 0);
      model_cnt = 0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.done_o || bus.gmii_dv_o != '0) n++;
      end
      check("rst_quiet", n, 0);
      return;
    end
    sz = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    nbad = 0;
    for (int i = 0; i < sz; i++) if (got_q[i] !== exp_q[i]) nbad++;
    check("dv_cycles", got_q.size(), exp_q.size());
    check("frame_bytes", nbad, 0);
    if (got_q.size() == exp_q.size() && sz >= 4)
      check("fcs", {got_q[sz-1], got_q[sz-2], got_q[sz-3], got_q[sz-4]},
                   {exp_q[sz-1], exp_q[sz-2], exp_q[sz-3], exp_q[sz-4]});
    check("er_count", er_n, (re && l > 0) ? 1 : 0);
    check("er_pos", er_at, (re && l > 0) ? 22 : -1);
    check("other_ports", other, 0);
    model_cnt++;
    check("done_pulse", bus.done_o, 1);
    check("frame_cnt", bus.frame_cnt_o, 16'(model_cnt));
    @(negedge clk);
    check("done_once", bus.done_o, 0);
    n = 2;
    while (bus.ready_o !== 1'b1 && n < 100) begin
      if (bus.gmii_dv_o != '0) other++;
      @(negedge clk);
      n++;
    end
    check("idle_to_ready", n, IFG);
    check("ifg_dv_low", other, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, seen, frames, cyc, nz;
    rst = 1'b1;
    bus.start_i = 1'b1;
    bus.port_sel_i = '0;
    bus.dst_mac_i = '0;
    bus.src_mac_i = '0;
    bus.eth_type_i = '0;
    bus.payload_len_i = 11'd46;
    bus.fcs_err_i = 1'b0;
    bus.rx_er_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nz = 0;
    for (int p = 0; p < NP; p++) if (bus.gmii_data_o[p] != 8'h00) nz++;
    check("reset_ready", bus.ready_o, 1);
    check("reset_done", bus.done_o, 0);
    check("reset_frame_cnt", bus.frame_cnt_o, 0);
    check("reset_dv", bus.gmii_dv_o, 0);
    check("reset_er", bus.gmii_er_o, 0);
    check("reset_data", nz, 0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("start_in_reset_ignored", bus.gmii_dv_o, 0);

    send(0, 48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 46, 1'b0, 1'b0, -1);
    check("byte8_dst", got_q[8], 8'hFF);
    send(1, 48'h0A0B_0C0D_0E0F, 48'h1234_5678_9ABC, 16'h86DD, 10, 1'b0, 1'b0, -1);
    send(2, 48'hDEAD_BEEF_0001, 48'h0200_0000_0002, 16'h88B5, 2000, 1'b0, 1'b0, -1);
    send(3, 48'h0102_0304_0506, 48'hA1A2_A3A4_A5A6, 16'h0806, 0, 1'b0, 1'b1, -1);
    send(1, 48'h5555_AAAA_5555, 48'hC0FF_EE00_1122, 16'h0800, 5, 1'b1, 1'b1, -1);
    send(2, 48'h0123_4567_89AB, 48'hFEDC_BA98_7654, 16'h0800, 40, 1'b0, 1'b0, 42);

    // start held high: frames run back to back
    bus.port_sel_i = 2'd3;
    bus.payload_len_i = 11'd0;
    bus.fcs_err_i = 1'b0;
    bus.rx_er_i = 1'b0;
    bus.start_i = 1'b1;
    low = 0; seen = 0; frames = 0; cyc = 0;
    while (frames < 3 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus.gmii_dv_o[3]) begin
        if (seen != 0 && low > 0) check("b2b_gap", low, IFG);
        low = 0;
        seen = 1;
      end else if (seen != 0) low++;
      if (bus.done_o) frames++;
    end
    bus.start_i = 1'b0;
    check("b2b_frames", frames, 3);
    repeat (30) @(negedge clk);
    model_cnt += 3;
    check("b2b_frame_cnt", bus.frame_cnt_o, 16'(model_cnt));
    check("b2b_ready", bus.ready_o, 1);

    for (int k = 0; k < 6; k++)
      send(int'($urandom_range(0, NP - 1)), 48'({$urandom(), $urandom()}),
           48'({$urandom(), $urandom()}), 16'($urandom()),
           int'($urandom_range(0, 120)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gmii_frame_gen.md
GMII_FRAME_GEN -- requirements
Module: gmii_frame_gen

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of GMII output channels.
REQ-002 Parameter DATA_WIDTH, default 8: GMII byte width; only 8 supported.
REQ-003 Parameter MAX_PAYLOAD, default 1500: payload length ceiling in bytes.
REQ-004 Parameter IFG_CYCLES, default 12: minimum idle cycles after each frame; legal range is 12 or more.
REQ-005 gmii_clk_i  in  1  sole clock; all logic is on its rising edge.
REQ-006 gmii_rst_i  in  1  synchronous, active-high reset.
REQ-007 start_i  in  1  frame request; accepted only while ready_o=1.
REQ-008 port_sel_i  in  $clog2(NUM_PORTS)  target channel for the frame.
REQ-009 dst_mac_i / src_mac_i  in  48 each  MAC addresses; bits 47:40 are transmitted first.
REQ-010 eth_type_i  in  16  EtherType; bits 15:8 are transmitted first.
REQ-011 payload_len_i  in  11  requested payload length in bytes.
REQ-012 fcs_err_i  in  1  corrupt the FCS of this frame.
REQ-013 rx_er_i  in  1  assert er on payload byte 0 of this frame.
REQ-014 ready_o  out  1  generator is idle and can accept start_i.
REQ-015 done_o  out  1  one-cycle pulse at frame completion.
REQ-016 frame_cnt_o  out  16  count of completed frames; wraps at 2^16.
REQ-017 gmii_data_o[NUM_PORTS]  out  8 each  per-channel data.
REQ-018 gmii_dv_o[NUM_PORTS] and gmii_er_o[NUM_PORTS]  out  1 each  per-channel data-valid and error.

Function
REQ-019 Handshake: start_i=1 with ready_o=1 at edge T latches all request inputs and deasserts ready_o at T+1; start_i while ready_o=0 is ignored and not queued.
REQ-020 FSM states: IDLE, PREAMBLE, SFD, DST, SRC, TYPE, PAYLOAD, PAD, FCS, IFG; each state outputs one byte per cycle.
REQ-021 Sequence: PREAMBLE is 7 bytes of 0x55, then SFD 0xD5, then DST 6 bytes, SRC 6 bytes, TYPE 2 bytes, PAYLOAD, PAD, FCS 4 bytes, IFG for IFG_CYCLES cycles, then IDLE.
REQ-022 The first preamble byte is driven at T+1, with dv=1 on the selected channel.
REQ-023 PAYLOAD byte i is i[7:0], for i from 0 to L-1, where L = min(payload_len_i, MAX_PAYLOAD).
REQ-024 PAD sends max(0, 46-L) bytes of 0x00; with L=0, PAYLOAD is skipped and 46 pad bytes are sent.
REQ-025 FCS: IEEE 802.3 CRC-32, reflected, polynomial 0x04C11DB7, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
REQ-026 CRC coverage: DST through the last PAD byte; the CRC is updated one byte per cycle with no stall.
REQ-027 FCS transmission order: bits 7:0 first, through bits 31:24 last.
REQ-028 With fcs_err latched, the first FCS byte is sent with bit 0 inverted; all other bytes are unchanged.
REQ-029 With rx_er latched and L>0, gmii_er_o=1 for payload byte 0 only; with L=0, er is never asserted.
REQ-030 dv=1 from the first preamble byte through the last FCS byte inclusive, and dv=0 during IFG and IDLE.
REQ-031 Unselected channels, and all channels in IFG or IDLE, drive data=0x00, dv=0, er=0.
REQ-032 done_o pulses in the first IFG cycle, and frame_cnt_o increments in that same cycle.
REQ-033 ready_o returns to 1 in the cycle after the last IFG cycle, so the earliest back-to-back start gives exactly IFG_CYCLES idle cycles between frames.
REQ-034 Width rules: all byte, state and CRC counters are sized to MAX_PAYLOAD+46 with no truncation; frame_cnt_o wraps from 0xFFFF to 0x0000.
REQ-035 All outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-036 While gmii_rst_i=1 at an edge, the next cycle shows FSM=IDLE, ready_o=1, done_o=0, frame_cnt_o=0, and all channels at data=0, dv=0, er=0.
REQ-037 Reset asserted mid-frame aborts the frame: dv drops in the next cycle, with no done_o pulse and no IFG.
REQ-038 start_i asserted during the reset cycle is ignored.

Verification
REQ-039 Port 0 frame, dst FF:FF:FF:FF:FF:FF, src 00:11:22:33:44:55, type 0x0800, L=46 -> dv high for 72 cycles, byte 8 is 0xFF, FCS equals the bench CRC-32 model, done_o=1, frame_cnt_o=1.
REQ-040 L=10 on port 1 -> payload bytes 00 through 09, then 36 pad bytes of 0x00, dv high for 72 cycles, FCS correct; ports 0, 2 and 3 stay at dv=0.
REQ-041 L=2000 -> clamped to 1500, dv high for 1526 cycles; L=0 -> 46 pad bytes, dv high for 72 cycles.
REQ-042 fcs_err_i=1 -> first FCS byte equals the model byte XOR 0x01; rx_er_i=1 -> er=1 exactly at payload byte 0.
REQ-043 start_i held at 1 continuously -> exactly 12 dv-low cycles between frames; start pulses while busy are dropped, and frame_cnt_o counts only accepted frames.
REQ-044 Reset pulse at payload byte 20 -> dv=0 in the next cycle, no done_o pulse, frame_cnt_o=0, ready_o=1.
